reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Drives the single write port of the architectural register file (regWrite / wrAddr / wrData) on behalf of two writers.
- Writer 1 is the in-order pipeline writeback. It has priority and no handshake.
- Writer 2 is a long-latency unit (mult/div/load-miss) with a valid/ready handshake. Its results are buffered in a small FIFO and drained into idle write-port slots.
- Also reports read-after-write hazards for the two decode read addresses, and requests a pipeline stall when the FIFO head starves.

Parameters:
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, cycles a FIFO head may wait before stall_req is raised.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pipe_regWrite  in  1  pipeline writeback request this cycle.
- pipe_wrAddr  in  5  pipeline destination register.
- pipe_wrData  in  32  pipeline write data.
- lng_valid  in  1  long-latency result offered.
- lng_addr  in  5  long-latency destination register.
- lng_data  in  32  long-latency result data.
- lng_ready  out  1  FIFO can accept this cycle.
- rdAddr1, rdAddr2  in  5 each  decode read addresses.
- hazard1, hazard2  out  1 each  a write to rdAddrN is pending.
- stall_req  out  1  upstream must hold pipe_regWrite low next cycle.
- regWrite  out  1  register-file write enable (registered).
- wrAddr  out  5  register-file write address (registered).
- wrData  out  32  register-file write data (registered).

Behaviour:
- Reset (reset high at an edge):
  - regWrite=0, wrAddr=0, wrData=0, stall_req=0.
  - FIFO emptied, age counter=0.
  - lng_ready=0 while reset is high; lng_ready=1 in the first cycle after reset. Any in-flight FIFO contents are discarded.
- Write-port outputs are registered. A request granted at edge N appears on regWrite/wrAddr/wrData during the cycle after edge N. The register file commits it at edge N+1.
- Pipeline requests with wrAddr=0 are treated as no request. They consume no slot and produce no output.
- Grant at each edge, in priority order:
  - (a) if stall_req==1 and the FIFO is non-empty: pop the FIFO head to the output.
  - (b) else if a valid pipe request exists: drive the pipe request.
  - (c) else if the FIFO is non-empty: pop the head.
  - (d) else: regWrite=0, and wrAddr/wrData hold their previous values.
- A pipe request while stall_req==1 is a protocol violation: flag it with an assertion. The RTL gives the FIFO the slot and drops the pipe write.
- FIFO:
  - lng_ready = (count < DEPTH), registered-count based.
  - A push occurs on lng_valid && lng_ready at an edge. lng_addr=0 is accepted (handshake completes) but not stored.
  - There is no bypass: a pushed entry is eligible to pop no earlier than the next edge. Minimum latency from handshake to regWrite high is 2 cycles.
  - Push and pop in the same edge are allowed: count is unchanged.
  - When full, lng_ready=0, so no push coincides with a full FIFO. Pointers wrap modulo DEPTH.
  - Entries from the long-latency unit retire in order.
- Starvation:
  - The age counter increments each edge the FIFO is non-empty and its head is not popped. It resets to 0 on a pop or when the FIFO is empty.
  - The counter saturates at STARVE_MAX.
  - stall_req is registered: it is 1 during the cycle after the counter reaches STARVE_MAX, and stays high until the starved head pops. It returns to 0 the cycle after that pop.
- Hazards (combinational):
  - hazardN = (rdAddrN != 0) && (rdAddrN matches any valid FIFO entry, or (regWrite && wrAddr==rdAddrN)).
  - The output-stage term is required because the register file read path is combinational and the write commits only at the next edge.
- A pipe write and a FIFO entry to the same register: order is defined by grant order. No merging.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, and REG_ZERO=5'd0.
  - A packed wb_req type {addr, data} used for FIFO entries.
- One natural sub-module: wb_fifo. It is a parameterized sync FIFO with count, full/empty, and per-entry address outputs for hazard compare. The arbiter, age counter and hazard logic stay in the top.

Test Plan:
- Reset for 2 cycles, then idle:
  - Required: regWrite=0, lng_ready=1, stall_req=0, hazard1=hazard2=0.
- Pipe writes r5=0x11 at edge N:
  - Required: regWrite=1, wrAddr=5, wrData=0x11 in the cycle after N.
  - Required: hazard1=1 that cycle for rdAddr1=5; hazard1=0 the following cycle.
- lng push r7=0xAB with no pipe traffic at edge N:
  - Required: hazard2=1 for rdAddr2=7 after N.
  - Required: regWrite with wrAddr=7, wrData=0xAB in the cycle after N+1.
- Pipe writes every cycle; lng pushes r3=0x1 and r4=0x2:
  - Required: lng_ready=0 after the second push.
  - Required: stall_req=1 after STARVE_MAX=4 waiting edges.
  - With pipe_regWrite held low: r3 retires, then r4, in order; stall_req drops after r3 pops.
- Pipe write to r0 and lng push to r0:
  - Required: no regWrite pulse, FIFO count unchanged, hazards stay 0 for rdAddr=0.
- Reset asserted with 2 entries queued:
  - Required: the FIFO empties, no writes occur after reset, and lng_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared widths and the buffered writeback request type for the register-file write arbiter.
package reg_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback requests; exposes per-entry addresses so the
// top can compare every queued destination against the decode read addresses.
module wb_fifo
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  wb_req_t                               push_req,
    input  logic                                  pop,
    output wb_req_t                               head,
    output logic [CNT_W-1:0]                      count,
    output logic                                  full,
    output logic                                  empty,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr,
    output logic [DEPTH-1:0]                      entry_valid
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] off;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_req;
    end

    // An entry is live when its distance from the read pointer (mod DEPTH) is below count.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - rd_ptr_q;
            entry_addr[i]  = mem_q[i].addr;
            entry_valid[i] = CNT_W'(off) < count_q;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results
// are queued and drained into idle slots, with starvation stall and RAW hazard reporting.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_regWrite,
    input  logic [REG_ADDR_W-1:0] pipe_wrAddr,
    input  logic [REG_DATA_W-1:0] pipe_wrData,
    input  logic                  lng_valid,
    input  logic [REG_ADDR_W-1:0] lng_addr,
    input  logic [REG_DATA_W-1:0] lng_data,
    output logic                  lng_ready,
    input  logic [REG_ADDR_W-1:0] rdAddr1,
    input  logic [REG_ADDR_W-1:0] rdAddr2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  stall_req,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] wrAddr,
    output logic [REG_DATA_W-1:0] wrData
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    wb_req_t                          fifo_head;
    logic [CNT_W-1:0]                 fifo_count;
    logic                             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
    logic [DEPTH-1:0]                 entry_valid;
    logic                             pipe_valid, grant_pipe;

    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;
    logic [AGE_W-1:0]      age_q, age_d;
    logic                  stall_req_q, stall_req_d;

    assign pipe_valid = pipe_regWrite && (pipe_wrAddr != REG_ZERO);
    assign lng_ready  = !reset && (fifo_count < CNT_W'(DEPTH));
    // Writes to r0 complete the handshake but are never stored.
    assign fifo_push  = lng_valid && lng_ready && (lng_addr != REG_ZERO);
    assign fifo_pop   = !fifo_empty && (stall_req_q || !pipe_valid);
    assign grant_pipe = pipe_valid && !fifo_pop;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_req   ('{addr: lng_addr, data: lng_data}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .entry_addr (entry_addr),
        .entry_valid(entry_valid)
    );

    always_comb begin
        reg_write_d = fifo_pop || grant_pipe;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (fifo_pop) begin
            wr_addr_d = fifo_head.addr;
            wr_data_d = fifo_head.data;
        end else if (grant_pipe) begin
            wr_addr_d = pipe_wrAddr;
            wr_data_d = pipe_wrData;
        end

        if (fifo_empty || fifo_pop) age_d = '0;
        else if (age_q != AGE_MAX)  age_d = age_q + 1'b1;
        else                        age_d = age_q;
        stall_req_d = (age_d == AGE_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            age_q       <= '0;
            stall_req_q <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            age_q       <= age_d;
            stall_req_q <= stall_req_d;
        end
    end

    // Output stage counts as pending: the register file commits it only at the next edge.
    always_comb begin
        hazard1 = reg_write_q && (wr_addr_q == rdAddr1);
        hazard2 = reg_write_q && (wr_addr_q == rdAddr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == rdAddr1)) hazard1 = 1'b1;
            if (entry_valid[i] && (entry_addr[i] == rdAddr2)) hazard2 = 1'b1;
        end
        if (rdAddr1 == REG_ZERO) hazard1 = 1'b0;
        if (rdAddr2 == REG_ZERO) hazard2 = 1'b0;
    end

    assign regWrite  = reg_write_q;
    assign wrAddr    = wr_addr_q;
    assign wrData    = wr_data_q;
    assign stall_req = stall_req_q;

    pipe_write_during_stall: assert property (@(posedge clk) disable iff (reset)
        !(stall_req_q && pipe_valid))
        else $error("pipeline write requested while stall_req is high");

    no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full))
        else $error("long-latency push into a full queue");

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: each task drives one scenario and checks inline.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_regWrite;
    logic [4:0]  pipe_wrAddr;
    logic [31:0] pipe_wrData;
    logic        lng_valid;
    logic [4:0]  lng_addr;
    logic [31:0] lng_data;
    logic        lng_ready;
    logic [4:0]  rdAddr1, rdAddr2;
    logic        hazard1, hazard2, stall_req, regWrite;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .DEPTH     (2),
        .STARVE_MAX(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_regWrite(pipe_regWrite),
        .pipe_wrAddr  (pipe_wrAddr),
        .pipe_wrData  (pipe_wrData),
        .lng_valid    (lng_valid),
        .lng_addr     (lng_addr),
        .lng_data     (lng_data),
        .lng_ready    (lng_ready),
        .rdAddr1      (rdAddr1),
        .rdAddr2      (rdAddr2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .stall_req    (stall_req),
        .regWrite     (regWrite),
        .wrAddr       (wrAddr),
        .wrData       (wrData)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pipe_regWrite = 1'b0; pipe_wrAddr = '0; pipe_wrData = '0;
        lng_valid = 1'b0; lng_addr = '0; lng_data = '0; rdAddr1 = 5'd5; rdAddr2 = 5'd7;
        step();
        checks++; if (lng_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b want 0", lng_ready); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b want 0", regWrite); end
        checks++; if (wrAddr !== 5'd0 || wrData !== 32'd0) begin errors++; $display("FAIL rst_addr_data: got %0d/%h want 0/0", wrAddr, wrData); end
        checks++; if (lng_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", lng_ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_req); end
        checks++; if ({hazard1, hazard2} !== 2'b00) begin errors++; $display("FAIL rst_hazards: got %b want 00", {hazard1, hazard2}); end
    endtask

    task automatic test_pipe_write();
        pipe_regWrite = 1'b1; pipe_wrAddr = 5'd5; pipe_wrData = 32'h11; rdAddr1 = 5'd5;
        step();
        pipe_regWrite = 1'b0;
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd5, 32'h11}) begin errors++; $display("FAIL pipe_out: got %b/%0d/%h want 1/5/11", regWrite, wrAddr, wrData); end
        checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL pipe_hazard_outstage: got %b want 1", hazard1); end
        step();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL pipe_single_pulse: got %b want 0", regWrite); end
        checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL pipe_hazard_clear: got %b want 0", hazard1); end
        checks++; if ({wrAddr, wrData} !== {5'd5, 32'h11}) begin errors++; $display("FAIL idle_hold: got %0d/%h want 5/11", wrAddr, wrData); end
    endtask

    task automatic test_lng_push();
        lng_valid = 1'b1; lng_addr = 5'd7; lng_data = 32'hAB; rdAddr2 = 5'd7;
        step();
        lng_valid = 1'b0;
        checks++; if (hazard2 !== 1'b1) begin errors++; $display("FAIL lng_hazard_queued: got %b want 1", hazard2); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL lng_no_bypass: got %b want 0", regWrite); end
        step();
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd7, 32'hAB}) begin errors++; $display("FAIL lng_out: got %b/%0d/%h want 1/7/ab", regWrite, wrAddr, wrData); end
        checks++; if (hazard2 !== 1'b1) begin errors++; $display("FAIL lng_hazard_outstage: got %b want 1", hazard2); end
        step();
        checks++; if ({regWrite, hazard2} !== 2'b00) begin errors++; $display("FAIL lng_drained: got %b want 00", {regWrite, hazard2}); end
    endtask

    task automatic test_starvation();
        rdAddr1 = 5'd3; rdAddr2 = 5'd4;
        pipe_regWrite = 1'b1; pipe_wrAddr = 5'd10; pipe_wrData = 32'hA0;
        lng_valid = 1'b1; lng_addr = 5'd3; lng_data = 32'h1;
        step();
        checks++; if (lng_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_one: got %b want 1", lng_ready); end
        checks++; if ({regWrite, wrAddr} !== {1'b1, 5'd10}) begin errors++; $display("FAIL starve_pipe_prio: got %b/%0d want 1/10", regWrite, wrAddr); end
        lng_addr = 5'd4; lng_data = 32'h2; pipe_wrData = 32'hA1;
        step();
        lng_valid = 1'b0;
        checks++; if (lng_ready !== 1'b0) begin errors++; $display("FAIL starve_full: got %b want 0", lng_ready); end
        checks++; if ({hazard1, hazard2} !== 2'b11) begin errors++; $display("FAIL starve_hazards: got %b want 11", {hazard1, hazard2}); end
        step();
        step();
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_early: got %b want 0", stall_req); end
        step();
        pipe_regWrite = 1'b0;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", stall_req); end
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd10, 32'hA1}) begin errors++; $display("FAIL starve_pipe_out: got %b/%0d/%h want 1/10/a1", regWrite, wrAddr, wrData); end
        step();
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd3, 32'h1}) begin errors++; $display("FAIL starve_pop_r3: got %b/%0d/%h want 1/3/1", regWrite, wrAddr, wrData); end
        checks++; if ({stall_req, lng_ready} !== 2'b01) begin errors++; $display("FAIL starve_release: got %b want 01", {stall_req, lng_ready}); end
        step();
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd4, 32'h2}) begin errors++; $display("FAIL starve_pop_r4: got %b/%0d/%h want 1/4/2", regWrite, wrAddr, wrData); end
        step();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL starve_empty: got %b want 0", regWrite); end
    endtask

    task automatic test_back_to_back();
        lng_valid = 1'b1; lng_addr = 5'd20; lng_data = 32'h20;
        step();
        lng_addr = 5'd21; lng_data = 32'h21;
        step();
        lng_valid = 1'b0;
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd20, 32'h20}) begin errors++; $display("FAIL b2b_first: got %b/%0d/%h want 1/20/20", regWrite, wrAddr, wrData); end
        checks++; if (lng_ready !== 1'b1) begin errors++; $display("FAIL b2b_count_kept: got %b want 1", lng_ready); end
        step();
        checks++; if ({regWrite, wrAddr, wrData} !== {1'b1, 5'd21, 32'h21}) begin errors++; $display("FAIL b2b_second: got %b/%0d/%h want 1/21/21", regWrite, wrAddr, wrData); end
        step();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", regWrite); end
    endtask

    task automatic test_zero_reg();
        rdAddr1 = 5'd0; rdAddr2 = 5'd0;
        pipe_regWrite = 1'b1; pipe_wrAddr = 5'd0; pipe_wrData = 32'hFF;
        lng_valid = 1'b1; lng_addr = 5'd0; lng_data = 32'hEE;
        step();
        pipe_regWrite = 1'b0; lng_valid = 1'b0;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_no_write: got %b want 0", regWrite); end
        checks++; if ({hazard1, hazard2} !== 2'b00) begin errors++; $display("FAIL r0_hazards: got %b want 00", {hazard1, hazard2}); end
        step();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_not_queued: got %b want 0", regWrite); end
    endtask

    task automatic test_reset_flush();
        rdAddr1 = 5'd8; rdAddr2 = 5'd9;
        pipe_regWrite = 1'b1; pipe_wrAddr = 5'd12; pipe_wrData = 32'hC0;
        lng_valid = 1'b1; lng_addr = 5'd8; lng_data = 32'h88;
        step();
        checks++; if (lng_ready !== 1'b1) begin errors++; $display("FAIL flush_r0_uncounted: got %b want 1", lng_ready); end
        lng_addr = 5'd9; lng_data = 32'h99;
        step();
        lng_valid = 1'b0; pipe_regWrite = 1'b0;
        checks++; if ({lng_ready, hazard1, hazard2} !== 3'b011) begin errors++; $display("FAIL flush_queued: got %b want 011", {lng_ready, hazard1, hazard2}); end
        reset = 1'b1;
        #1;
        checks++; if (lng_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_in_reset: got %b want 0", lng_ready); end
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if ({lng_ready, hazard1, hazard2, regWrite} !== 4'b1000) begin errors++; $display("FAIL flush_after_reset: got %b want 1000", {lng_ready, hazard1, hazard2, regWrite}); end
        step();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL flush_no_write1: got %b want 0", regWrite); end
        step();
        checks++; if ({regWrite, stall_req} !== 2'b00) begin errors++; $display("FAIL flush_no_write2: got %b want 00", {regWrite, stall_req}); end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_lng_push();
        test_starvation();
        test_back_to_back();
        test_zero_reg();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
